// File: rtl/pipelined_processor.sv
// pipelined_processor
//   Four-stage in-order pipeline (IF, ID, EX, WB) with a built-in instruction
//   ROM, an 8-entry register file and a small ALU. Full forwarding means the
//   pipeline never stalls. A HALT instruction freezes the fetch address.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   reset    : asynchronous, active-high reset
//   pc_out   : current fetch address
//   wb_en    : EX/WB holds a register-writing instruction (commits next edge)
//   wb_addr  : destination register held in EX/WB
//   wb_data  : result held in EX/WB
//   halted   : a HALT has reached EX/WB; sticky until reset
//
// Instruction word: op[15:12] rd[11:9] rs1[8:6] rs2[5:3], imm8[7:0] for LDI.
// PROGRAM packs the ROM with entry i at bits [16*i +: 16].
module pipelined_processor #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_DEPTH = 16,
    parameter logic [IMEM_DEPTH*16-1:0] PROGRAM = {
        {((IMEM_DEPTH - 8) * 16){1'b0}},
        16'hF000, 16'h5F30, 16'h4CD0, 16'h3AD0,
        16'h28C8, 16'h1650, 16'h6403, 16'h6205
    }
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc_out,
    output logic                          wb_en,
    output logic [2:0]                    wb_addr,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          halted
);

    localparam int unsigned PC_W = $clog2(IMEM_DEPTH);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_HALT = 4'hF
    } op_e;

    // Fetch state
    logic [PC_W-1:0]   r_pc;
    logic              r_ifid_valid;
    logic [15:0]       r_ifid_instr;

    // ID/EX
    logic              r_idex_valid;
    logic [3:0]        r_idex_op;
    logic [2:0]        r_idex_rd;
    logic [2:0]        r_idex_rs1;
    logic [2:0]        r_idex_rs2;
    logic [DATA_W-1:0] r_idex_a;
    logic [DATA_W-1:0] r_idex_b;
    logic [7:0]        r_idex_imm;

    // EX/WB
    logic              r_exwb_en;
    logic [2:0]        r_exwb_addr;
    logic [DATA_W-1:0] r_exwb_data;
    logic              r_halted;

    logic [DATA_W-1:0] r_rf [8];

    logic [15:0]       w_fetch;
    logic              w_fetch_halt;
    logic [2:0]        w_id_rs1;
    logic [2:0]        w_id_rs2;
    logic [DATA_W-1:0] w_id_a;
    logic [DATA_W-1:0] w_id_b;
    logic [DATA_W-1:0] w_ex_a;
    logic [DATA_W-1:0] w_ex_b;
    logic [DATA_W-1:0] w_ex_res;
    logic              w_ex_wr;

    // IF: ROM lookup; a HALT at the fetch address pins the PC there.
    always_comb begin
        w_fetch      = PROGRAM[{r_pc, 4'b0000} +: 16];
        w_fetch_halt = (w_fetch[15:12] == OP_HALT);
    end

    // ID: register read with write-through from the instruction committing
    // this cycle (covers distance-2 dependencies). r0 always reads zero.
    always_comb begin
        w_id_rs1 = r_ifid_instr[8:6];
        w_id_rs2 = r_ifid_instr[5:3];
        w_id_a   = r_rf[w_id_rs1];
        w_id_b   = r_rf[w_id_rs2];
        if (r_exwb_en && (r_exwb_addr == w_id_rs1)) w_id_a = r_exwb_data;
        if (r_exwb_en && (r_exwb_addr == w_id_rs2)) w_id_b = r_exwb_data;
        if (w_id_rs1 == 3'd0) w_id_a = '0;
        if (w_id_rs2 == 3'd0) w_id_b = '0;
    end

    // EX: distance-1 forwarding from EX/WB, then the ALU.
    always_comb begin
        w_ex_a   = r_idex_a;
        w_ex_b   = r_idex_b;
        w_ex_res = '0;
        w_ex_wr  = 1'b0;
        if (r_exwb_en && (r_exwb_addr == r_idex_rs1) && (r_idex_rs1 != 3'd0))
            w_ex_a = r_exwb_data;
        if (r_exwb_en && (r_exwb_addr == r_idex_rs2) && (r_idex_rs2 != 3'd0))
            w_ex_b = r_exwb_data;
        if (r_idex_valid) begin
            case (r_idex_op)
                OP_ADD: begin w_ex_wr = 1'b1; w_ex_res = w_ex_a + w_ex_b; end
                OP_SUB: begin w_ex_wr = 1'b1; w_ex_res = w_ex_a - w_ex_b; end
                OP_AND: begin w_ex_wr = 1'b1; w_ex_res = w_ex_a & w_ex_b; end
                OP_OR:  begin w_ex_wr = 1'b1; w_ex_res = w_ex_a | w_ex_b; end
                OP_XOR: begin w_ex_wr = 1'b1; w_ex_res = w_ex_a ^ w_ex_b; end
                OP_LDI: begin w_ex_wr = 1'b1; w_ex_res = DATA_W'(r_idex_imm); end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_idex_valid <= 1'b0;
            r_idex_op    <= '0;
            r_idex_rd    <= '0;
            r_idex_rs1   <= '0;
            r_idex_rs2   <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_exwb_en    <= 1'b0;
            r_exwb_addr  <= '0;
            r_exwb_data  <= '0;
            r_halted     <= 1'b0;
        end else begin
            // IF
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= w_fetch;
            if (!w_fetch_halt)
                r_pc <= (r_pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : r_pc + 1'b1;
            // ID
            r_idex_valid <= r_ifid_valid;
            r_idex_op    <= r_ifid_instr[15:12];
            r_idex_rd    <= r_ifid_instr[11:9];
            r_idex_rs1   <= w_id_rs1;
            r_idex_rs2   <= w_id_rs2;
            r_idex_a     <= w_id_a;
            r_idex_b     <= w_id_b;
            r_idex_imm   <= r_ifid_instr[7:0];
            // EX
            r_exwb_en    <= w_ex_wr;
            r_exwb_addr  <= w_ex_wr ? r_idex_rd : 3'd0;
            r_exwb_data  <= w_ex_res;
            if (r_idex_valid && (r_idex_op == OP_HALT))
                r_halted <= 1'b1;
        end
    end

    // WB: writes to r0 are dropped so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++)
                r_rf[i] <= '0;
        end else if (r_exwb_en && (r_exwb_addr != 3'd0)) begin
            r_rf[r_exwb_addr] <= r_exwb_data;
        end
    end

    assign pc_out  = r_pc;
    assign wb_en   = r_exwb_en;
    assign wb_addr = r_exwb_addr;
    assign wb_data = r_exwb_data;
    assign halted  = r_halted;

endmodule

// File: tb/tb_pipelined_processor.sv
// Testbench for pipelined_processor: default program, forwarding, HALT,
// asynchronous mid-program reset, and an alternate ROM that writes r0 and
// wraps the PC. EX/WB results are matched against a queue of expected
// writes filled when each program run is started.
module tb_pipelined_processor;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [7:0] data;
    } wb_t;

    // Alternate ROM: LDI r1,7 ; ADD r0,r1,r1 ; ADD r2,r0,r1 ; NOPs, no HALT.
    localparam logic [255:0] ALT_PROG = {
        {13{16'h0000}}, 16'h1408, 16'h1048, 16'h6207
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset2 = 1'b1;
    logic [3:0] pc_out, pc_out2;
    logic       wb_en, wb_en2;
    logic [2:0] wb_addr, wb_addr2;
    logic [7:0] wb_data, wb_data2;
    logic       halted, halted2;

    int checks = 0;
    int errors = 0;
    wb_t sb[$];

    always #5 clk = ~clk;

    pipelined_processor dut (
        .clk     (clk),
        .reset   (reset),
        .pc_out  (pc_out),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .halted  (halted)
    );

    pipelined_processor #(.PROGRAM(ALT_PROG)) dut2 (
        .clk     (clk),
        .reset   (reset2),
        .pc_out  (pc_out2),
        .wb_en   (wb_en2),
        .wb_addr (wb_addr2),
        .wb_data (wb_data2),
        .halted  (halted2)
    );

    task automatic test_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({pc_out, wb_en, wb_addr, wb_data, halted} !== 17'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: pc=%0d wb_en=%b addr=%0d data=%h halted=%b, want all 0",
                         c, pc_out, wb_en, wb_addr, wb_data, halted);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.r_rf[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_rf r%0d: got %h want 00", i, dut.r_rf[i]);
            end
        end
    endtask

    // Restart the default program and check the EX/WB stream cycle by cycle.
    task automatic test_program();
        logic [2:0] ea [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] ed [7] = '{8'h05, 8'h03, 8'h08, 8'h03, 8'h00, 8'h0B, 8'h08};
        wb_t e;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        for (int i = 0; i < 7; i++) sb.push_back('{cyc: 3 + i, addr: ea[i], data: ed[i]});
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_out !== ((c < 7) ? 4'(c) : 4'd7)) begin
                errors++;
                $display("FAIL prog_pc cyc %0d: got %0d want %0d", c, pc_out, (c < 7) ? c : 7);
            end
            checks++;
            if (halted !== (c >= 10)) begin
                errors++;
                $display("FAIL prog_halted cyc %0d: got %b want %b", c, halted, c >= 10);
            end
            if (wb_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL prog_extra_wb cyc %0d: got r%0d=%h want no write", c, wb_addr, wb_data);
                end else begin
                    e = sb.pop_front();
                    if (wb_addr !== e.addr || wb_data !== e.data || c != e.cyc) begin
                        errors++;
                        $display("FAIL prog_wb cyc %0d: got r%0d=%h want r%0d=%h at cyc %0d",
                                 c, wb_addr, wb_data, e.addr, e.data, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && c >= sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL prog_missing_wb cyc %0d: got wb_en=%b want r%0d=%h", c, wb_en, sb[0].addr, sb[0].data);
                void'(sb.pop_front());
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL prog_drain: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_forwarding();
        checks++;
        if (dut.r_rf[3] !== 8'h08) begin
            errors++;
            $display("FAIL fwd_r3: got %h want 08", dut.r_rf[3]);
        end
        checks++;
        if (dut.r_rf[7] !== 8'h08) begin
            errors++;
            $display("FAIL fwd_r7: got %h want 08", dut.r_rf[7]);
        end
    endtask

    task automatic test_halt();
        logic [7:0] er [8] = '{8'h00, 8'h05, 8'h03, 8'h08, 8'h03, 8'h00, 8'h0B, 8'h08};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_out !== 4'd7 || wb_en !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold: got pc=%0d wb_en=%b halted=%b want pc=7 wb_en=0 halted=1",
                         pc_out, wb_en, halted);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.r_rf[i] !== er[i]) begin
                errors++;
                $display("FAIL halt_rf r%0d: got %h want %h", i, dut.r_rf[i], er[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (pc_out !== 4'd5 || dut.r_rf[1] !== 8'h05) begin
            errors++;
            $display("FAIL async_pre: got pc=%0d r1=%h want pc=5 r1=05", pc_out, dut.r_rf[1]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_out, wb_en, wb_addr, wb_data, halted} !== 17'd0) begin
            errors++;
            $display("FAIL async_outputs: got pc=%0d wb_en=%b addr=%0d data=%h halted=%b want all 0",
                     pc_out, wb_en, wb_addr, wb_data, halted);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.r_rf[i] !== 8'h00) begin
                errors++;
                $display("FAIL async_rf r%0d: got %h want 00", i, dut.r_rf[i]);
            end
        end
        test_program();
        test_halt();
    endtask

    task automatic test_r0_wrap();
        wb_t e;
        @(negedge clk);
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{cyc: 3 + 16 * k, addr: 3'd1, data: 8'h07});
            sb.push_back('{cyc: 4 + 16 * k, addr: 3'd0, data: 8'h0E});
            sb.push_back('{cyc: 5 + 16 * k, addr: 3'd2, data: 8'h07});
        end
        reset2 = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pc_out2 !== 4'(c % 16) || halted2 !== 1'b0) begin
                errors++;
                $display("FAIL wrap_pc cyc %0d: got pc=%0d halted=%b want pc=%0d halted=0",
                         c, pc_out2, halted2, c % 16);
            end
            checks++;
            if (dut2.r_rf[0] !== 8'h00) begin
                errors++;
                $display("FAIL wrap_r0 cyc %0d: got %h want 00", c, dut2.r_rf[0]);
            end
            if (wb_en2 === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra_wb cyc %0d: got r%0d=%h want no write", c, wb_addr2, wb_data2);
                end else begin
                    e = sb.pop_front();
                    if (wb_addr2 !== e.addr || wb_data2 !== e.data || c != e.cyc) begin
                        errors++;
                        $display("FAIL wrap_wb cyc %0d: got r%0d=%h want r%0d=%h at cyc %0d",
                                 c, wb_addr2, wb_data2, e.addr, e.data, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && c >= sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL wrap_missing_wb cyc %0d: got wb_en=%b want r%0d=%h", c, wb_en2, sb[0].addr, sb[0].data);
                void'(sb.pop_front());
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain: got %0d pending want 0", sb.size());
        end
        checks++;
        if (dut2.r_rf[2] !== 8'h07 || dut2.r_rf[1] !== 8'h07) begin
            errors++;
            $display("FAIL wrap_rf: got r1=%h r2=%h want r1=07 r2=07", dut2.r_rf[1], dut2.r_rf[2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_program();
        test_forwarding();
        test_halt();
        test_async_reset();
        test_r0_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_processor.md
Name: pipelined_processor

Overview:
- Four-stage in-order pipelined processor: IF, ID, EX, WB.
- Built-in 16-entry instruction ROM, 8 x 8-bit register file and 8-bit ALU.
- Full forwarding, so the pipeline never stalls. No branches; a HALT instruction freezes fetch.
- Top-level compute block. Only clock and reset are required; the remaining outputs are observation/debug ports and may be left unconnected.

Parameters:
- DATA_W, 8, datapath and register width.
- IMEM_DEPTH, 16, instruction ROM entries; PC width = log2(IMEM_DEPTH) = 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_out  output  4  current PC (fetch address).
- wb_en  output  1  EX/WB holds a valid register-writing instruction; the write commits at the next rising edge.
- wb_addr  output  3  destination register held in EX/WB.
- wb_data  output  8  result held in EX/WB.
- halted  output  1  a HALT has reached EX/WB; sticky until reset.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, reset). While reset=1:
  - PC=0.
  - IF/ID, ID/EX and EX/WB are invalid (behave as NOP).
  - All registers r0-r7 = 0.
  - wb_en=0, wb_addr=0, wb_data=0, halted=0, pc_out=0.
  - Reset asserted mid-program aborts all in-flight instructions at once; the program restarts from PC 0 after release.
- Instruction format (16 bits):
  - op = [15:12]
  - rd = [11:9]
  - rs1 = [8:6]
  - rs2 = [5:3]
  - imm8 = [7:0] (LDI only)
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI rd=imm8
  - F HALT
  - Any other opcode: treated as NOP (no write).
- Arithmetic: 8-bit, modulo 256. No flags and no carry-out.
- r0 always reads 0. Writes to r0 are discarded: wb_en still asserts, but r0 stays 0.
- Stage actions per rising edge:
  - IF: IF/ID <= imem[PC]; PC <= PC+1, wrapping 15->0.
  - ID: register file read combinationally into ID/EX.
  - EX: ALU result into EX/WB.
  - WB: register file write.
- Latency: the instruction fetched at PC=k, with no HALT before it, is in EX/WB after rising edge k+3 following reset release, and is committed at edge k+4.
- Forwarding:
  - EX/WB destination equals an EX source register (and is not r0): the EX/WB result replaces that operand.
  - Register file write-through: a register being written in the same cycle it is read in ID returns the new value.
  - Together these cover dependencies at distance 1 and 2; distance 3 or more reads the register file.
- HALT:
  - When imem[PC] is HALT, PC holds at that address. HALT (a non-writing NOP) keeps entering IF/ID.
  - Older instructions drain normally.
  - halted goes to 1 once a HALT occupies EX/WB and stays 1.
- Default ROM program (addresses 0-7; entries 8-15 = 0000):
  - 6205 LDI r1,5
  - 6403 LDI r2,3
  - 1650 ADD r3,r1,r2
  - 28C8 SUB r4,r3,r1
  - 3AD0 AND r5,r3,r2
  - 4CD0 OR r6,r3,r2
  - 5F30 XOR r7,r4,r6
  - F000 HALT

Test Plan:
- Hold reset=1 for 200 ns with clk toggling -> pc_out=0, wb_en=0, halted=0 throughout; all registers 0.
- Assert reset at 6 ns, release after 2 edges, run the default program -> EX/WB sequence: (r1,05), (r2,03), (r3,08), (r4,03), (r5,00), (r6,0B), (r7,08) on consecutive cycles; first entry after edge 3.
- Same run, forwarding check -> r3=08 proves distance-1 (r2) and distance-2 (r1) forwarding; r7=08 proves distance-1 (r6) and distance-3 (r4).
- Same run, HALT check -> pc_out freezes at 7; halted=1 one cycle after the r7 write is shown; wb_en stays 0 afterwards; final registers r1..r7 = 05,03,08,03,00,0B,08.
- Assert reset asynchronously between clock edges mid-program -> all outputs return to reset values immediately, without waiting for a clock edge; after release the program reruns with identical results.
- ROM with an ADD into r0 and no HALT -> r0 reads 0; PC wraps 15->0 and execution continues.
